// File: rtl/led_pattern_if.sv
// Pattern controller bus: divided-clock input, control inputs and LED/status outputs.
interface led_pattern_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             clk_div_in;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] led;
    logic             step;
    logic [CNT_W-1:0] step_cnt;
    logic             dir_left;

    modport master (
        output clk_div_in, en, mode,
        input  led, step, step_cnt, dir_left
    );

    modport slave (
        input  clk_div_in, en, mode,
        output led, step, step_cnt, dir_left
    );
endinterface

// File: rtl/led_pattern_ctrl.sv
// LED pattern stepper driven by synchronized rising edges of a divided clock.
// Define LED_BOUNCE_EN to enable bounce mode; otherwise mode 3 behaves as shift-left.
module led_pattern_ctrl #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic          clk,
    input  logic          rst,
    led_pattern_if.slave  bus
);

    typedef enum logic [1:0] {
        S_FLASH = 2'd0,
        S_SHL   = 2'd1,
        S_SHR   = 2'd2,
        S_BNC   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] LED_LSB = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LED_MSB = {1'b1, {(WIDTH-1){1'b0}}};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   step_q;
    state_t                 state, state_next;
    logic [1:0]             mode_q;
    logic                   mode_change;
    logic [WIDTH-1:0]       led_q, led_next;
    logic [CNT_W-1:0]       cnt_q, cnt_next;
`ifdef LED_BOUNCE_EN
    logic                   dir_q, dir_next;
`endif

    assign mode_change = (bus.mode != mode_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            step_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.clk_div_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            step_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_FLASH;
            mode_q <= 2'd0;
        end else begin
            state  <= state_next;
            mode_q <= bus.mode;
        end
    end

    always_comb begin
        state_next = state;
        if (mode_change) begin
            case (bus.mode)
                2'd0:    state_next = S_FLASH;
                2'd1:    state_next = S_SHL;
                2'd2:    state_next = S_SHR;
`ifdef LED_BOUNCE_EN
                default: state_next = S_BNC;
`else
                default: state_next = S_SHL;
`endif
            endcase
        end
    end

    // A mode change reloads the pattern and swallows any coincident step.
    always_comb begin
        led_next = led_q;
        cnt_next = cnt_q;
`ifdef LED_BOUNCE_EN
        dir_next = dir_q;
`endif
        if (mode_change) begin
            case (state_next)
                S_FLASH: led_next = '1;
                S_SHR:   led_next = LED_MSB;
`ifdef LED_BOUNCE_EN
                S_BNC: begin
                    led_next = LED_LSB;
                    dir_next = 1'b1;
                end
`endif
                default: led_next = LED_LSB;
            endcase
        end else if (step_q && bus.en) begin
            cnt_next = cnt_q + 1'b1;
            case (state)
                S_FLASH: led_next = ~led_q;
                S_SHR:   led_next = {led_q[0], led_q[WIDTH-1:1]};
`ifdef LED_BOUNCE_EN
                S_BNC: begin
                    led_next = dir_q ? (led_q << 1) : (led_q >> 1);
                    if (led_next[WIDTH-1])
                        dir_next = 1'b0;
                    else if (led_next[0])
                        dir_next = 1'b1;
                end
`endif
                default: led_next = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q <= '0;
            cnt_q <= '0;
`ifdef LED_BOUNCE_EN
            dir_q <= 1'b1;
`endif
        end else begin
            led_q <= led_next;
            cnt_q <= cnt_next;
`ifdef LED_BOUNCE_EN
            dir_q <= dir_next;
`endif
        end
    end

    assign bus.led      = led_q;
    assign bus.step     = step_q;
    assign bus.step_cnt = cnt_q;
`ifdef LED_BOUNCE_EN
    assign bus.dir_left = dir_q;
`else
    assign bus.dir_left = 1'b1;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed self-checking bench for led_pattern_ctrl (WIDTH=16, SYNC_STAGES=2, CNT_W=8).
module tb_led_pattern_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    int   pulses;
    int   exp_cnt;
    int   highs;

    led_pattern_if #(.WIDTH(16), .CNT_W(8)) bus ();

    led_pattern_ctrl #(.WIDTH(16), .SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One full divided-clock period; counts how many step pulses were seen.
    task automatic applyStimulus(output int seen);
        seen = 0;
        bus.clk_div_in = 1'b1;
        repeat (4) begin
            tick;
            if (bus.step === 1'b1) seen++;
        end
        bus.clk_div_in = 1'b0;
        repeat (4) begin
            tick;
            if (bus.step === 1'b1) seen++;
        end
    endtask

    initial begin
        bus.clk_div_in = 1'b0;
        bus.en         = 1'b1;
        bus.mode       = 2'd2;

        // T1: reset with clk_div_in toggling
        #2 rst = 1'b0;
        repeat (6) begin
            tick;
            bus.clk_div_in = ~bus.clk_div_in;
        end
        checkOutput("rst_led", 32'(bus.led), 32'h0000);
        checkOutput("rst_step", 32'(bus.step), 32'h0);
        checkOutput("rst_cnt", 32'(bus.step_cnt), 32'h0);
        checkOutput("rst_dir", 32'(bus.dir_left), 32'h1);
        bus.clk_div_in = 1'b0;
        rst = 1'b1;
        tick;
        checkOutput("rst_reload_shr", 32'(bus.led), 32'h8000);
        checkOutput("rst_reload_cnt", 32'(bus.step_cnt), 32'h0);
        exp_cnt = 0;

        // T2: edge-detect latency
        bus.clk_div_in = 1'b1;
        tick;
        checkOutput("lat_edge1", 32'(bus.step), 32'h0);
        tick;
        checkOutput("lat_edge2", 32'(bus.step), 32'h0);
        tick;
        checkOutput("lat_edge3", 32'(bus.step), 32'h1);
        tick;
        checkOutput("lat_edge4", 32'(bus.step), 32'h0);
        checkOutput("lat_shr_led", 32'(bus.led), 32'h4000);
        exp_cnt = 1;
        checkOutput("lat_cnt", 32'(bus.step_cnt), 32'(exp_cnt));
        bus.clk_div_in = 1'b0;
        highs = 0;
        repeat (5) begin
            tick;
            if (bus.step === 1'b1) highs++;
        end
        checkOutput("lat_fall_nostep", 32'(highs), 32'h0);

        // T6: freeze with en=0 in shift-right mode
        bus.en = 1'b0;
        highs = 0;
        repeat (5) begin
            applyStimulus(pulses);
            highs += pulses;
        end
        checkOutput("frz_pulses", 32'(highs), 32'd5);
        checkOutput("frz_led", 32'(bus.led), 32'h4000);
        checkOutput("frz_cnt", 32'(bus.step_cnt), 32'(exp_cnt));
        bus.en = 1'b1;
        applyStimulus(pulses);
        exp_cnt++;
        checkOutput("frz_resume_led", 32'(bus.led), 32'h2000);
        checkOutput("frz_resume_cnt", 32'(bus.step_cnt), 32'(exp_cnt));

        // T3: shift-left with wrap
        bus.mode = 2'd1;
        tick;
        checkOutput("shl_reload", 32'(bus.led), 32'h0001);
        checkOutput("shl_reload_cnt", 32'(bus.step_cnt), 32'(exp_cnt));
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(pulses);
            exp_cnt++;
            checkOutput($sformatf("shl_step%0d", k), 32'(bus.led), 32'h1 << (k % 16));
        end
        checkOutput("shl_cnt", 32'(bus.step_cnt), 32'd18);

        // T4: bounce (or shl alias when bounce is compiled out)
        bus.mode = 2'd3;
        tick;
        checkOutput("bnc_reload", 32'(bus.led), 32'h0001);
        checkOutput("bnc_reload_dir", 32'(bus.dir_left), 32'h1);
`ifdef LED_BOUNCE_EN
        for (int k = 1; k <= 30; k++) begin
            applyStimulus(pulses);
            exp_cnt++;
            checkOutput($sformatf("bnc_led%0d", k), 32'(bus.led),
                        (k <= 15) ? (32'h1 << k) : (32'h1 << (30 - k)));
            checkOutput($sformatf("bnc_dir%0d", k), 32'(bus.dir_left),
                        (k < 15 || k == 30) ? 32'h1 : 32'h0);
        end
        checkOutput("bnc_cnt", 32'(bus.step_cnt), 32'd48);
        bus.mode = 2'd1;
        tick;
        checkOutput("bnc_to_shl", 32'(bus.led), 32'h0001);
`else
        applyStimulus(pulses);
        exp_cnt++;
        checkOutput("m3_as_shl", 32'(bus.led), 32'h0002);
        checkOutput("m3_dir_tied", 32'(bus.dir_left), 32'h1);
        checkOutput("m3_cnt", 32'(bus.step_cnt), 32'd19);
        bus.mode = 2'd1;
        tick;
        checkOutput("m3_to_shl", 32'(bus.led), 32'h0001);
`endif

        // T5: mode change coincident with a step
        bus.clk_div_in = 1'b1;
        repeat (3) tick;
        checkOutput("sim_step_high", 32'(bus.step), 32'h1);
        bus.mode = 2'd0;
        tick;
        checkOutput("sim_reload", 32'(bus.led), 32'hFFFF);
        checkOutput("sim_cnt_hold", 32'(bus.step_cnt), 32'(exp_cnt));
        bus.clk_div_in = 1'b0;
        repeat (4) tick;
        applyStimulus(pulses);
        exp_cnt++;
        checkOutput("sim_flash_toggle", 32'(bus.led), 32'h0000);
        checkOutput("sim_cnt", 32'(bus.step_cnt), 32'(exp_cnt));
        applyStimulus(pulses);
        checkOutput("flash_toggle2", 32'(bus.led), 32'hFFFF);

        // Asynchronous reset mid-pattern, then release with mode matching mode_q
        #3 rst = 1'b0;
        #1;
        checkOutput("async_rst_led", 32'(bus.led), 32'h0000);
        checkOutput("async_rst_cnt", 32'(bus.step_cnt), 32'h0);
        tick;
        rst = 1'b1;
        tick;
        checkOutput("post_rst_flash_noreload", 32'(bus.led), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
